ahb_apb_bridge_gen2: RTL and testbench
======================================

// Module: ahb_apb_bridge_gen2
// PURPOSE
//  Parametrised AHB-Lite to APB3 bridge, successor to the fixed 3-slave/32-bit bridge.
//  Generic address/data width and slave count. Adds PREADY wait states, PSLVERR and decode-miss
//  error responses, and an APB timeout. Back-to-back AHB transfers are accepted without an idle cycle.
// PARAMETERS
//  ADDR_W      32           AHB/APB address width
//  DATA_W      32           AHB/APB data width
//  NUM_SLAVES  3            APB slaves (1..16); SEL_W = max(1, clog2(NUM_SLAVES))
//  REGION_BITS 12           byte-address bits per slave region
//  BASE_ADDR   32'h8000_0000  bridge window base; upper bits [ADDR_W-1:REGION_BITS+SEL_W] are compared
//  TIMEOUT     16           max ACCESS cycles waiting for Pready; 0 = no timeout
// PORTS
//  Hclk       in   1             clock
//  Hresetn    in   1             asynchronous reset, active low
//  Hwrite     in   1             AHB write
//  Hreadyin   in   1             AHB bus ready
//  Htrans     in   2             AHB transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
//  Haddr      in   ADDR_W        AHB address
//  Hwdata     in   DATA_W        AHB write data (data phase)
//  Hreadyout  out  1             AHB ready
//  Hresp      out  2             00 OKAY, 01 ERROR
//  Hrdata     out  DATA_W        AHB read data
//  Prdata     in   DATA_W        APB read data (externally muxed)
//  Pready     in   1             APB ready (externally muxed)
//  Pslverr    in   1             APB slave error (externally muxed)
//  Pselx      out  NUM_SLAVES    one-hot APB select
//  Penable    out  1             APB enable
//  Pwrite     out  1             APB write
//  Paddr      out  ADDR_W        APB address (full captured Haddr)
//  Pwdata     out  DATA_W        APB write data
// BEHAVIOUR
//  Reset (async, any state): Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hreadyout=1,
//   Hresp=00, Hrdata=0, state=IDLE, timeout count=0. An APB transfer in flight is abandoned.
//  Sampling points: IDLE, ERR2, and the ACCESS cycle that completes with Pready=1 and Pslverr=0.
//  At a sampling point, valid = Hreadyin & Htrans[1] & window hit.
//  Invalid or out-of-window transfers are ignored: OKAY response, zero wait.
//  Decode: idx = Haddr[REGION_BITS+SEL_W-1:REGION_BITS]. On valid, capture Haddr, Hwrite and idx.
//  Next state on valid: idx>=NUM_SLAVES -> ERR1; write -> WDATA; read -> SETUP.
//  FSM (Hreadyout / Hresp / APB outputs):
//   IDLE:   Hreadyout=1, Hresp=00, Pselx=0, Penable=0.
//   WDATA:  Hreadyout=0. Latch Hwdata into Pwdata. -> SETUP.
//   SETUP:  Pselx[idx]=1, Penable=0, Paddr and Pwrite valid, Hreadyout=0. -> ACCESS.
//   ACCESS: Pselx[idx]=1, Penable=1.
//     Pready=0: Hreadyout=0; timeout counter increments.
//     Pready=1, Pslverr=0: Hreadyout=1 and Hrdata=Prdata in the same cycle (reads only);
//       sample next transfer, then -> IDLE / WDATA / SETUP / ERR1.
//     Pready=1, Pslverr=1: Hreadyout=0, -> ERR1.
//     TIMEOUT>0 and Pready still low on the TIMEOUT-th ACCESS cycle: -> ERR1.
//   ERR1:   Hresp=01, Hreadyout=0, Pselx=0, Penable=0. -> ERR2.
//   ERR2:   Hresp=01, Hreadyout=1. Sampling point (same rules as IDLE).
//  Hrdata = 0 except during a successful read completion cycle.
//  Pwrite, Paddr and Pwdata hold their last value while idle.
//  Latency: read with Pready=1 completes 2 cycles after the address phase; write completes 3.
//   Each Pready=0 cycle adds one cycle.
//  Timeout counter clears on entry to SETUP. Pslverr is ignored while Pready=0.
// TESTING
//  1 Reset asserted mid-ACCESS -> same edge: Pselx=0, Penable=0, Hreadyout=1, Hresp=00;
//    after release, IDLE.
//  2 Read, Haddr=0x8000_1004, Pready=1, Prdata=0xDEADBEEF -> cycle+1 SETUP with Pselx=3'b010;
//    cycle+2 Penable=1, Hreadyout=1, Hrdata=0xDEADBEEF, Hresp=00.
//  3 Write, Haddr=0x8000_0010, Hwdata=0x12345678, Pready low for 2 cycles
//    -> Pwdata=0x12345678, Pwrite=1, Pselx=3'b001; Hreadyout low for 4 cycles.
//  4 Read to slave 2 with Pready=1, Pslverr=1 -> ERR1 (Hresp=01, Hreadyout=0),
//    then ERR2 (Hresp=01, Hreadyout=1).
//  5 NUM_SLAVES=3, Haddr=0x8000_3000 -> no Pselx asserted; two-cycle ERROR response.
//    Haddr=0x4000_0000 -> ignored, OKAY.
//  6 TIMEOUT=16, Pready stuck at 0 -> after 16 ACCESS cycles Pselx=0, two-cycle ERROR.
//    A back-to-back NONSEQ read at the completion cycle -> SETUP on the next cycle, no IDLE gap.

Source files
------------

// File: rtl/ahb_apb_bridge_gen2.sv
// AHB-Lite to APB3 bridge: parametrised slave count, PREADY wait states,
// PSLVERR / decode-miss error responses, APB timeout, back-to-back transfers.
module ahb_apb_bridge_gen2 #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       NUM_SLAVES  = 3,
    parameter int unsigned       REGION_BITS = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned       TIMEOUT     = 16
) (
    input  logic                  Hclk,
    input  logic                  Hresetn,
    input  logic                  Hwrite,
    input  logic                  Hreadyin,
    input  logic [1:0]            Htrans,
    input  logic [ADDR_W-1:0]     Haddr,
    input  logic [DATA_W-1:0]     Hwdata,
    output logic                  Hreadyout,
    output logic [1:0]            Hresp,
    output logic [DATA_W-1:0]     Hrdata,
    input  logic [DATA_W-1:0]     Prdata,
    input  logic                  Pready,
    input  logic                  Pslverr,
    output logic [NUM_SLAVES-1:0] Pselx,
    output logic                  Penable,
    output logic                  Pwrite,
    output logic [ADDR_W-1:0]     Paddr,
    output logic [DATA_W-1:0]     Pwdata
);

    localparam int unsigned SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned DEC_LO = REGION_BITS + SEL_W;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_SETUP,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                state, state_nxt;
    logic [SEL_W-1:0]      sel_idx;
    logic [CNT_W-1:0]      tmo_cnt;
    logic [SEL_W-1:0]      dec_idx;
    logic [NUM_SLAVES-1:0] sel_onehot;
    logic                  win_hit, idx_miss, xfer_ok, sample_pt, valid, tmo_hit;
    logic                  htrans_unused;

    assign htrans_unused = Htrans[0];
    assign win_hit    = (Haddr[ADDR_W-1:DEC_LO] == BASE_ADDR[ADDR_W-1:DEC_LO]);
    assign dec_idx    = Haddr[DEC_LO-1:REGION_BITS];
    assign idx_miss   = ({1'b0, dec_idx} >= (SEL_W+1)'(NUM_SLAVES));
    assign xfer_ok    = (state == S_ACCESS) && Pready && !Pslverr;
    // A new address phase may be taken while idle, in the second error cycle,
    // or in the same cycle a clean APB completion releases the AHB bus.
    assign sample_pt  = (state == S_IDLE) || (state == S_ERR2) || xfer_ok;
    assign valid      = sample_pt && Hreadyin && Htrans[1] && win_hit;
    assign tmo_hit    = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
    assign sel_onehot = NUM_SLAVES'(1) << sel_idx;

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state   <= S_IDLE;
            sel_idx <= '0;
            tmo_cnt <= '0;
            Paddr   <= '0;
            Pwrite  <= 1'b0;
            Pwdata  <= '0;
        end else begin
            state <= state_nxt;
            if (valid) begin
                Paddr   <= Haddr;
                Pwrite  <= Hwrite;
                sel_idx <= dec_idx;
            end
            if (state == S_WDATA) Pwdata <= Hwdata;
            if (state == S_SETUP) tmo_cnt <= '0;
            else if (state == S_ACCESS && !Pready) tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_ERR2: state_nxt = S_IDLE;
            S_WDATA:        state_nxt = S_SETUP;
            S_SETUP:        state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (Pready)       state_nxt = Pslverr ? S_ERR1 : S_IDLE;
                else if (tmo_hit) state_nxt = S_ERR1;
            end
            S_ERR1:         state_nxt = S_ERR2;
            default:        state_nxt = S_IDLE;
        endcase
        if (valid) state_nxt = idx_miss ? S_ERR1 : (Hwrite ? S_WDATA : S_SETUP);
    end

    always_comb begin
        Hreadyout = 1'b1;
        Hresp     = 2'b00;
        Hrdata    = '0;
        Pselx     = '0;
        Penable   = 1'b0;
        unique case (state)
            S_WDATA: Hreadyout = 1'b0;
            S_SETUP: begin
                Hreadyout = 1'b0;
                Pselx     = sel_onehot;
            end
            S_ACCESS: begin
                Pselx     = sel_onehot;
                Penable   = 1'b1;
                Hreadyout = xfer_ok;
                if (xfer_ok && !Pwrite) Hrdata = Prdata;
            end
            S_ERR1: begin
                Hresp     = 2'b01;
                Hreadyout = 1'b0;
            end
            S_ERR2: Hresp = 2'b01;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_apb_bridge_gen2.sv
// Bench for ahb_apb_bridge_gen2: directed read/reset checks, then random AHB
// traffic against an APB slave model, scored by a transfer-level reference model.
module tb_ahb_apb_bridge_gen2;

    localparam int unsigned TMO = 16;

    logic        Hclk, Hresetn, Hwrite, Hreadyin, Hreadyout;
    logic [1:0]  Htrans, Hresp;
    logic [31:0] Haddr, Hwdata, Hrdata, Prdata, Paddr, Pwdata;
    logic        Pready, Pslverr, Penable, Pwrite;
    logic [2:0]  Pselx;
    logic        stall, mon_on;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [2:0]  sel;
        int unsigned waits;
        logic        err;
        logic [31:0] rdata;
    } xfer_t;

    typedef struct {
        int unsigned cycles;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;

    exp_t  exp_q[$];
    xfer_t apb_q[$];

    assign Hreadyin = Hreadyout & ~stall;

    ahb_apb_bridge_gen2 #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3), .REGION_BITS(12),
        .BASE_ADDR(32'h8000_0000), .TIMEOUT(TMO)
    ) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
        .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Hreadyout(Hreadyout),
        .Hresp(Hresp), .Hrdata(Hrdata), .Prdata(Prdata), .Pready(Pready),
        .Pslverr(Pslverr), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata)
    );

    initial begin
        Hclk = 1'b0;
        forever #5 Hclk = ~Hclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endfunction

    // Transfer-level reference: response, data-phase length and APB involvement.
    function automatic void model(input xfer_t p, output exp_t e, output bit need_apb);
        logic        hit;
        int unsigned idx, base;
        hit  = (p.addr[31:14] == 18'h2_0000);
        idx  = 32'(p.addr[13:12]);
        base = p.write ? 3 : 2;
        e.rdata  = '0;
        need_apb = 1'b0;
        if (!hit) begin
            e.cycles = 1; e.resp = 2'b00;
        end else if (idx >= 3) begin
            e.cycles = 2; e.resp = 2'b01;
        end else begin
            need_apb = 1'b1;
            if (p.waits >= TMO) begin
                e.cycles = base - 1 + TMO + 2; e.resp = 2'b01;
            end else if (p.err) begin
                e.cycles = base + p.waits + 2; e.resp = 2'b01;
            end else begin
                e.cycles = base + p.waits; e.resp = 2'b00;
                e.rdata  = p.write ? 32'h0 : p.rdata;
            end
        end
    endfunction

    function automatic xfer_t gen();
        xfer_t       p;
        int unsigned r;
        r = $urandom_range(0, 11);
        case (r)
            0:       p.addr = 32'h4000_0000 | ($urandom & 32'h0000_FFFC);
            1:       p.addr = $urandom;
            2:       p.addr = 32'h8000_3000 | ($urandom & 32'h0000_0FFC);
            3:       p.addr = 32'h8000_1004;
            4:       p.addr = 32'h8000_0010;
            default: p.addr = 32'h8000_0000 | (32'($urandom_range(0, 2)) << 12) | ($urandom & 32'h0000_0FFC);
        endcase
        p.write = 1'($urandom);
        p.wdata = $urandom;
        p.rdata = $urandom;
        p.err   = ($urandom_range(0, 4) == 0);
        p.sel   = 3'b001 << p.addr[13:12];
        r = $urandom_range(0, 9);
        if (r < 6)       p.waits = 0;
        else if (r == 6) p.waits = $urandom_range(1, 3);
        else if (r == 7) p.waits = TMO - 1;
        else if (r == 8) p.waits = TMO;
        else             p.waits = 40;
        return p;
    endfunction

    // APB slave: follows the plan queued at acceptance, garbage elsewhere.
    initial begin
        xfer_t       cur;
        int unsigned wcnt;
        Pready = 1'b0; Pslverr = 1'b0; Prdata = '0;
        cur.waits = 0; cur.err = 1'b0; cur.rdata = '0;
        wcnt = 0;
        forever begin
            @(posedge Hclk); #1;
            if (Pselx != 3'b000 && !Penable) begin
                chk("apb_setup_expected", 64'(apb_q.size() != 0), 64'd1);
                if (apb_q.size() != 0) begin
                    cur = apb_q.pop_front();
                    chk("apb_pselx", 64'(Pselx), 64'(cur.sel));
                    chk("apb_paddr", 64'(Paddr), 64'(cur.addr));
                    chk("apb_pwrite", 64'(Pwrite), 64'(cur.write));
                    if (cur.write) chk("apb_pwdata", 64'(Pwdata), 64'(cur.wdata));
                end
                wcnt = 0;
                Pready = 1'($urandom); Pslverr = 1'($urandom); Prdata = $urandom;
            end else if (Pselx != 3'b000 && Penable) begin
                if (wcnt >= cur.waits) begin
                    Pready = 1'b1; Pslverr = cur.err; Prdata = cur.rdata;
                end else begin
                    Pready = 1'b0; Pslverr = 1'($urandom); Prdata = $urandom;
                end
                wcnt++;
            end else begin
                Pready = 1'($urandom); Pslverr = 1'($urandom); Prdata = $urandom;
            end
        end
    end

    // Monitor: pops one expected response per completed AHB data phase.
    initial begin
        exp_t        e;
        int unsigned cyc;
        logic        prev_ready;
        logic [1:0]  prev_resp;
        cyc = 0; prev_ready = 1'b1; prev_resp = 2'b00;
        forever begin
            @(negedge Hclk);
            if (mon_on) begin
                if (exp_q.size() != 0) begin
                    cyc++;
                    if (Hreadyout) begin
                        e = exp_q.pop_front();
                        chk("resp_cycles", 64'(cyc), 64'(e.cycles));
                        chk("resp_hresp", 64'(Hresp), 64'(e.resp));
                        chk("resp_hrdata", 64'(Hrdata), 64'(e.rdata));
                        if (e.resp == 2'b01) begin
                            chk("err_first_hresp", 64'(prev_resp), 64'd1);
                            chk("err_first_hready", 64'(prev_ready), 64'd0);
                        end
                        cyc = 0;
                    end else if (cyc > 64) begin
                        chk("data_phase_bound", 64'(cyc), 64'(exp_q[0].cycles));
                        void'(exp_q.pop_front());
                        cyc = 0;
                    end
                end else begin
                    chk("idle_hready", 64'(Hreadyout), 64'd1);
                    chk("idle_hresp", 64'(Hresp), 64'd0);
                    chk("idle_hrdata", 64'(Hrdata), 64'd0);
                end
            end
            prev_ready = Hreadyout;
            prev_resp  = Hresp;
        end
    end

    task automatic run_random(input int unsigned n);
        xfer_t       cur;
        exp_t        e;
        bit          have_cur, need;
        int unsigned issued, wait_cyc;
        logic        hr;
        have_cur = 1'b0; issued = 0; wait_cyc = 0;
        while (issued < n || have_cur) begin
            @(negedge Hclk);
            hr = Hreadyin;
            @(posedge Hclk);
            if (hr && have_cur) begin
                model(cur, e, need);
                exp_q.push_back(e);
                if (need) apb_q.push_back(cur);
                have_cur = 1'b0;
                wait_cyc = 0;
                #1;
                Hwdata = cur.write ? cur.wdata : $urandom;
            end else begin
                #1;
            end
            if (have_cur) begin
                wait_cyc++;
                if (wait_cyc > 200) begin
                    chk("addr_phase_accept", 64'(wait_cyc), 64'd0);
                    break;
                end
            end else if (issued < n) begin
                if ($urandom_range(0, 3) == 0) begin
                    Htrans = 2'($urandom_range(0, 1));
                    Haddr  = $urandom;
                    Hwrite = 1'($urandom);
                end else begin
                    cur = gen();
                    have_cur = 1'b1;
                    issued++;
                    Htrans = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
                    Haddr  = cur.addr;
                    Hwrite = cur.write;
                end
            end else begin
                Htrans = 2'b00;
            end
            stall = (exp_q.size() == 0) && ($urandom_range(0, 5) == 0);
        end
        Htrans = 2'b00;
        stall  = 1'b0;
    endtask

    initial begin
        xfer_t p;
        Hresetn = 1'b0; Hwrite = 1'b0; Htrans = 2'b00; Haddr = '0; Hwdata = '0;
        stall = 1'b0; mon_on = 1'b0;
        repeat (3) @(posedge Hclk);
        @(negedge Hclk);
        chk("rst_pselx", 64'(Pselx), 64'd0);
        chk("rst_penable", 64'(Penable), 64'd0);
        chk("rst_hready", 64'(Hreadyout), 64'd1);
        chk("rst_hresp", 64'(Hresp), 64'd0);
        chk("rst_hrdata", 64'(Hrdata), 64'd0);
        chk("rst_paddr", 64'(Paddr), 64'd0);
        chk("rst_pwdata", 64'(Pwdata), 64'd0);
        chk("rst_pwrite", 64'(Pwrite), 64'd0);
        @(posedge Hclk); #1 Hresetn = 1'b1;

        // Zero-wait read to slave 1.
        p.addr = 32'h8000_1004; p.write = 1'b0; p.wdata = '0; p.sel = 3'b010;
        p.waits = 0; p.err = 1'b0; p.rdata = 32'hDEAD_BEEF;
        apb_q.push_back(p);
        @(posedge Hclk); #1;
        Htrans = 2'b10; Haddr = p.addr; Hwrite = 1'b0;
        @(negedge Hclk);
        chk("rd_addr_hready", 64'(Hreadyout), 64'd1);
        @(posedge Hclk); #1 Htrans = 2'b00;
        @(negedge Hclk);
        chk("rd_setup_pselx", 64'(Pselx), 64'b010);
        chk("rd_setup_penable", 64'(Penable), 64'd0);
        chk("rd_setup_hready", 64'(Hreadyout), 64'd0);
        @(negedge Hclk);
        chk("rd_access_penable", 64'(Penable), 64'd1);
        chk("rd_access_hready", 64'(Hreadyout), 64'd1);
        chk("rd_access_hrdata", 64'(Hrdata), 64'hDEAD_BEEF);
        chk("rd_access_hresp", 64'(Hresp), 64'd0);
        @(negedge Hclk);
        chk("rd_after_pselx", 64'(Pselx), 64'd0);
        chk("rd_after_hrdata", 64'(Hrdata), 64'd0);

        // Reset while the slave stalls in ACCESS.
        p.addr = 32'h8000_0010; p.sel = 3'b001; p.waits = 1000; p.rdata = '0;
        apb_q.push_back(p);
        @(posedge Hclk); #1;
        Htrans = 2'b10; Haddr = p.addr; Hwrite = 1'b0;
        @(posedge Hclk); #1 Htrans = 2'b00;
        repeat (4) @(posedge Hclk);
        @(negedge Hclk);
        chk("mid_access_penable", 64'(Penable), 64'd1);
        chk("mid_access_hready", 64'(Hreadyout), 64'd0);
        #2 Hresetn = 1'b0;
        #1;
        chk("async_rst_pselx", 64'(Pselx), 64'd0);
        chk("async_rst_penable", 64'(Penable), 64'd0);
        chk("async_rst_hready", 64'(Hreadyout), 64'd1);
        chk("async_rst_hresp", 64'(Hresp), 64'd0);
        @(posedge Hclk); #1 Hresetn = 1'b1;
        @(negedge Hclk);
        chk("post_rst_pselx", 64'(Pselx), 64'd0);
        chk("post_rst_hready", 64'(Hreadyout), 64'd1);

        mon_on = 1'b1;
        run_random(300);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge Hclk);
        chk("drain_exp", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge Hclk);
        mon_on = 1'b0;
        chk("drain_apb", 64'(apb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
